dataslot_req_arbiter: RTL and testbench
=======================================

DATASLOT_REQ_ARBITER -- requirements
Module: dataslot_req_arbiter

Interface
REQ-001 Parameter N_CLIENTS, default 4, is the number of requesters and SHALL be in the range 2..8.
REQ-002 Parameter TIMEOUT_CYCLES, default 2^24, is the number of clk cycles before a downstream request is aborted.
REQ-003 Port clk, input, 1 bit: the single clock.
REQ-004 Port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port cli_valid, input, N_CLIENTS bits: per-client request, held high until the matching cli_done.
REQ-006 Port cli_write, input, N_CLIENTS bits: per-client opcode, 1 = dataslot write, 0 = dataslot read.
REQ-007 Port cli_param, input, N_CLIENTS x dataslot_xfer_param_t: per-client slot id, offset, bridge address and length.
REQ-008 Port cli_done, output, N_CLIENTS bits: one-cycle completion pulse to the granted client.
REQ-009 Port cli_result, output, 1 x dataslot_xfer_result_e: result code, valid only while a cli_done bit is high.
REQ-010 Port rd_valid, output, 1 bit: read request to core_dataslot_read_if.valid.
REQ-011 Port rd_param, output, core_dataslot_read_param_t: read request parameters.
REQ-012 Port rd_done, input, 1 bit: read completion.
REQ-013 Port rd_result, input, core_dataslot_read_result_e: read result.
REQ-014 Ports wr_valid, wr_param, wr_done and wr_result SHALL mirror REQ-010..013 for core_dataslot_write_if.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and RESP.
- IDLE: if any cli_valid bit is high, grant, capture and go to BUSY.
- BUSY: on rd_done or wr_done (for the issued op), go to RESP.
- RESP: go to IDLE.
REQ-016 Grant SHALL be round-robin.
- Search starts at last_grant+1, modulo N_CLIENTS.
- last_grant resets to N_CLIENTS-1, so client 0 wins first.
REQ-017 The opcode and param of the granted client SHALL be registered on the grant edge; later changes to cli_param SHALL be ignored.
REQ-018 rd_valid SHALL be high throughout BUSY when the captured op is read, and low otherwise; wr_valid SHALL behave the same for write.
REQ-019 rd_param/wr_param SHALL be driven from the captured param in BUSY and SHALL be zero otherwise.
REQ-020 In RESP, cli_done[grant] SHALL be high for exactly one cycle.
- cli_result = downstream result registered on the done cycle, zero-extended into dataslot_xfer_result_e.
REQ-021 A done input arriving for the non-issued op, or outside BUSY, SHALL be ignored.
REQ-022 A client dropping cli_valid while granted SHALL NOT abort the transfer; its cli_done SHALL still pulse.
REQ-023 Grant-to-rd_valid latency SHALL be 1 cycle; done-to-cli_done latency SHALL be 1 cycle.
REQ-024 The minimum gap between back-to-back grants SHALL be 3 cycles (BUSY, RESP, IDLE).
REQ-025 cli_done SHALL be one-hot or zero in every cycle.

Reset
REQ-026 While reset_n is low, the design SHALL immediately enter the following state:
- FSM = IDLE
- rd_valid, wr_valid, cli_done = 0
- params and cli_result = 0
- last_grant = N_CLIENTS-1
- timeout counter = 0
REQ-027 Reset during BUSY SHALL drop the downstream valid asynchronously and SHALL NOT emit any cli_done.

Configuration
REQ-028 With DATASLOT_ARB_TIMEOUT_EN defined, a counter SHALL clear on entry to BUSY and increment each BUSY cycle.
- At TIMEOUT_CYCLES-1 without done: drop the valid and go to RESP.
- cli_result = DATASLOT_XFER_TIMEOUT.
REQ-029 With DATASLOT_ARB_TIMEOUT_EN undefined, no counter SHALL exist and BUSY SHALL wait indefinitely.

Structure
REQ-030 Package bridge_pkg SHALL hold:
- dataslot_xfer_param_t
- dataslot_xfer_result_e, including DATASLOT_XFER_TIMEOUT
- the conversion functions dataslot_xfer_to_read_param and dataslot_xfer_to_write_param
REQ-031 The round-robin picker SHALL be the sub-module rr_arbiter, taking the request vector and last grant and returning a one-hot grant plus an index.

Verification
REQ-032 Reset release, then cli_valid=4'b0001 read, rd_done after 5 cycles with result 0 -> rd_valid high for 5 cycles, then cli_done=4'b0001 one cycle later, result 0.
REQ-033 cli_valid=4'b1111 held through 4 transfers -> grant order 0,1,2,3, and rd/wr chosen per cli_write.
REQ-034 cli_param changed mid-BUSY -> rd_param unchanged until done.
REQ-035 Timeout enabled, TIMEOUT_CYCLES=16, no done -> valid drops after 16 cycles and cli_result = DATASLOT_XFER_TIMEOUT.
REQ-036 reset_n low in BUSY -> rd_valid 0 asynchronously, no cli_done; after release, client 0 granted first again.
REQ-037 wr_done pulsed during a read transfer -> ignored, FSM stays BUSY.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types for the dataslot request arbiter: client transfer params,
// downstream core read/write params and results, and conversion helpers.
package bridge_pkg;

  typedef struct packed {
    logic [15:0] slot_id;
    logic [31:0] offset;
    logic [31:0] bridge_addr;
    logic [31:0] length;
  } dataslot_xfer_param_t;

  typedef struct packed {
    logic [15:0] slot_id;
    logic [31:0] slot_offset;
    logic [31:0] bridge_addr;
    logic [31:0] length;
  } core_dataslot_read_param_t;

  typedef struct packed {
    logic [15:0] slot_id;
    logic [31:0] slot_offset;
    logic [31:0] bridge_addr;
    logic [31:0] length;
  } core_dataslot_write_param_t;

  typedef enum logic [1:0] {
    CORE_DS_RD_OK         = 2'd0,
    CORE_DS_RD_ERR_SLOT   = 2'd1,
    CORE_DS_RD_ERR_RANGE  = 2'd2,
    CORE_DS_RD_ERR_BRIDGE = 2'd3
  } core_dataslot_read_result_e;

  typedef enum logic [1:0] {
    CORE_DS_WR_OK         = 2'd0,
    CORE_DS_WR_ERR_SLOT   = 2'd1,
    CORE_DS_WR_ERR_RANGE  = 2'd2,
    CORE_DS_WR_ERR_BRIDGE = 2'd3
  } core_dataslot_write_result_e;

  // Low codes track the core result codes one-to-one so a zero-extension converts them.
  typedef enum logic [2:0] {
    DATASLOT_XFER_OK         = 3'd0,
    DATASLOT_XFER_ERR_SLOT   = 3'd1,
    DATASLOT_XFER_ERR_RANGE  = 3'd2,
    DATASLOT_XFER_ERR_BRIDGE = 3'd3,
    DATASLOT_XFER_TIMEOUT    = 3'd4
  } dataslot_xfer_result_e;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  function automatic core_dataslot_read_param_t dataslot_xfer_to_read_param(
    input dataslot_xfer_param_t p
  );
    core_dataslot_read_param_t r;
    r.slot_id     = p.slot_id;
    r.slot_offset = p.offset;
    r.bridge_addr = p.bridge_addr;
    r.length      = p.length;
    return r;
  endfunction

  function automatic core_dataslot_write_param_t dataslot_xfer_to_write_param(
    input dataslot_xfer_param_t p
  );
    core_dataslot_write_param_t w;
    w.slot_id     = p.slot_id;
    w.slot_offset = p.offset;
    w.bridge_addr = p.bridge_addr;
    w.length      = p.length;
    return w;
  endfunction

  function automatic dataslot_xfer_result_e dataslot_xfer_from_read_result(
    input core_dataslot_read_result_e r
  );
    return dataslot_xfer_result_e'({1'b0, r});
  endfunction

  function automatic dataslot_xfer_result_e dataslot_xfer_from_write_result(
    input core_dataslot_write_result_e r
  );
    return dataslot_xfer_result_e'({1'b0, r});
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: first requester after last_grant (wrapping) wins.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant_oh,
  output logic [IW-1:0] grant_idx,
  output logic          grant_any
);

  // Scan N positions starting one past the last winner; first hit is kept.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    for (int i = 1; i <= N; i++) begin
      if (!grant_any && req[(int'(last_grant) + i) % N]) begin
        grant_any                               = 1'b1;
        grant_oh[(int'(last_grant) + i) % N]   = 1'b1;
        grant_idx                               = IW'((int'(last_grant) + i) % N);
      end
    end
  end

endmodule

// File: rtl/dataslot_req_arbiter.sv
// Arbitrates N client dataslot transfer requests onto the core read/write
// interfaces, one transfer at a time, round-robin.
// Optional BUSY watchdog: define DATASLOT_ARB_TIMEOUT_EN.
//
// state    | meaning
// ARB_IDLE | no transfer; grant the next requester if any
// ARB_BUSY | captured op issued downstream, waiting for its done
// ARB_RESP | one-cycle cli_done pulse to the granted client
module dataslot_req_arbiter
  import bridge_pkg::*;
#(
  parameter int N_CLIENTS      = 4,
  parameter int TIMEOUT_CYCLES = 1 << 24
) (
  input  logic                                 clk,
  input  logic                                 reset_n,
  input  logic [N_CLIENTS-1:0]                 cli_valid,
  input  logic [N_CLIENTS-1:0]                 cli_write,
  input  dataslot_xfer_param_t [N_CLIENTS-1:0] cli_param,
  output logic [N_CLIENTS-1:0]                 cli_done,
  output dataslot_xfer_result_e                cli_result,
  output logic                                 rd_valid,
  output core_dataslot_read_param_t            rd_param,
  input  logic                                 rd_done,
  input  core_dataslot_read_result_e           rd_result,
  output logic                                 wr_valid,
  output core_dataslot_write_param_t           wr_param,
  input  logic                                 wr_done,
  input  core_dataslot_write_result_e          wr_result
);

  localparam int IW = $clog2(N_CLIENTS);

  if (N_CLIENTS < 2 || N_CLIENTS > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("dataslot_req_arbiter: N_CLIENTS must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  arb_state_e            state_q, state_d;
  logic [N_CLIENTS-1:0]  grant_oh, grant_oh_q;
  logic [IW-1:0]         grant_idx, last_grant_q;
  logic                  grant_any;
  logic                  cap_write_q;
  dataslot_xfer_param_t  cap_param_q;
  dataslot_xfer_result_e result_q, rsp_val;
  logic                  rsp_load;
  logic                  timeout_hit;

  rr_arbiter #(.N(N_CLIENTS), .IW(IW)) u_rr (
    .req        (cli_valid),
    .last_grant (last_grant_q),
    .grant_oh   (grant_oh),
    .grant_idx  (grant_idx),
    .grant_any  (grant_any)
  );

`ifdef DATASLOT_ARB_TIMEOUT_EN
  localparam int               CNT_W   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] to_cnt_q;

  // Watchdog: zero on the grant edge, counts every BUSY cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_cnt_q <= '0;
    end else if (state_q == ARB_IDLE && grant_any) begin
      to_cnt_q <= '0;
    end else if (state_q == ARB_BUSY) begin
      to_cnt_q <= to_cnt_q + 1'b1;
    end
  end

  assign timeout_hit = (to_cnt_q == TO_LAST);
`else
  assign timeout_hit = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ARB_IDLE;
    else          state_q <= state_d;
  end

  // Next state and response selection; a real done wins over a same-cycle timeout.
  always_comb begin
    state_d  = state_q;
    rsp_load = 1'b0;
    rsp_val  = DATASLOT_XFER_OK;
    case (state_q)
      ARB_IDLE: if (grant_any) state_d = ARB_BUSY;
      ARB_BUSY: begin
        if (!cap_write_q && rd_done) begin
          state_d  = ARB_RESP;
          rsp_load = 1'b1;
          rsp_val  = dataslot_xfer_from_read_result(rd_result);
        end else if (cap_write_q && wr_done) begin
          state_d  = ARB_RESP;
          rsp_load = 1'b1;
          rsp_val  = dataslot_xfer_from_write_result(wr_result);
        end else if (timeout_hit) begin
          state_d  = ARB_RESP;
          rsp_load = 1'b1;
          rsp_val  = DATASLOT_XFER_TIMEOUT;
        end
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // Capture winner's op/param on the grant edge and latch the response code.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_write_q  <= 1'b0;
      cap_param_q  <= '0;
      grant_oh_q   <= '0;
      last_grant_q <= IW'(N_CLIENTS - 1);
      result_q     <= DATASLOT_XFER_OK;
    end else begin
      if (state_q == ARB_IDLE && grant_any) begin
        cap_write_q  <= cli_write[grant_idx];
        cap_param_q  <= cli_param[grant_idx];
        grant_oh_q   <= grant_oh;
        last_grant_q <= grant_idx;
      end
      if (rsp_load) result_q <= rsp_val;
    end
  end

  // Outputs decode straight from the state register, so reset drops them at once.
  always_comb begin
    rd_valid   = (state_q == ARB_BUSY) && !cap_write_q;
    wr_valid   = (state_q == ARB_BUSY) && cap_write_q;
    rd_param   = rd_valid ? dataslot_xfer_to_read_param(cap_param_q) : '0;
    wr_param   = wr_valid ? dataslot_xfer_to_write_param(cap_param_q) : '0;
    cli_done   = (state_q == ARB_RESP) ? grant_oh_q : '0;
    cli_result = result_q;
  end

endmodule

// File: tb/tb_dataslot_req_arbiter.sv
// Directed bench for dataslot_req_arbiter (4 clients, TIMEOUT_CYCLES=16).
// Timeout checks follow DATASLOT_ARB_TIMEOUT_EN.
module tb_dataslot_req_arbiter;
  import bridge_pkg::*;

  logic                          clk = 1'b0;
  logic                          reset_n;
  logic [3:0]                    cli_valid;
  logic [3:0]                    cli_write;
  dataslot_xfer_param_t [3:0]    cli_param;
  logic [3:0]                    cli_done;
  dataslot_xfer_result_e         cli_result;
  logic                          rd_valid;
  core_dataslot_read_param_t     rd_param;
  logic                          rd_done;
  core_dataslot_read_result_e    rd_result;
  logic                          wr_valid;
  core_dataslot_write_param_t    wr_param;
  logic                          wr_done;
  core_dataslot_write_result_e   wr_result;

  int n_total = 0;
  int n_pass  = 0;

  dataslot_req_arbiter #(.N_CLIENTS(4), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cli_valid  (cli_valid),
    .cli_write  (cli_write),
    .cli_param  (cli_param),
    .cli_done   (cli_done),
    .cli_result (cli_result),
    .rd_valid   (rd_valid),
    .rd_param   (rd_param),
    .rd_done    (rd_done),
    .rd_result  (rd_result),
    .wr_valid   (wr_valid),
    .wr_param   (wr_param),
    .wr_done    (wr_done),
    .wr_result  (wr_result)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100us");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic dataslot_xfer_param_t mk_param(input int i);
    dataslot_xfer_param_t p;
    p.slot_id     = 16'(16'h0100 + i);
    p.offset      = 32'(32'h1000_0000 + i * 256);
    p.bridge_addr = 32'(32'hF800_0000 + i * 16);
    p.length      = 32'(64 * (i + 1));
    return p;
  endfunction

  function automatic core_dataslot_read_param_t exp_rd(input int i);
    core_dataslot_read_param_t p;
    p.slot_id     = 16'(16'h0100 + i);
    p.slot_offset = 32'(32'h1000_0000 + i * 256);
    p.bridge_addr = 32'(32'hF800_0000 + i * 16);
    p.length      = 32'(64 * (i + 1));
    return p;
  endfunction

  function automatic core_dataslot_write_param_t exp_wr(input int i);
    core_dataslot_write_param_t p;
    p.slot_id     = 16'(16'h0100 + i);
    p.slot_offset = 32'(32'h1000_0000 + i * 256);
    p.bridge_addr = 32'(32'hF800_0000 + i * 16);
    p.length      = 32'(64 * (i + 1));
    return p;
  endfunction

  initial begin
    int n;
    logic w;
    reset_n   = 1'b0;
    cli_valid = '0;
    cli_write = '0;
    for (int i = 0; i < 4; i++) cli_param[i] = mk_param(i);
    rd_done   = 1'b0;
    rd_result = CORE_DS_RD_OK;
    wr_done   = 1'b0;
    wr_result = CORE_DS_WR_OK;

    // Reset state.
    @(negedge clk);
    tick();
    chk("rst_rd_valid", 128'(rd_valid), 128'(1'b0));
    chk("rst_wr_valid", 128'(wr_valid), 128'(1'b0));
    chk("rst_cli_done", 128'(cli_done), 128'(4'b0000));
    chk("rst_rd_param", 128'(rd_param), 128'(0));
    chk("rst_wr_param", 128'(wr_param), 128'(0));
    chk("rst_cli_result", 128'(cli_result), 128'(3'd0));

    // Single read from client 0, done on the 5th BUSY cycle.
    reset_n   = 1'b1;
    cli_valid = 4'b0001;
    tick();
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("t1_rd_valid_c%0d", k), 128'(rd_valid), 128'(1'b1));
      chk($sformatf("t1_cli_done_c%0d", k), 128'(cli_done), 128'(4'b0000));
      if (k == 1) chk("t1_rd_param", 128'(rd_param), 128'(exp_rd(0)));
      if (k == 5) begin
        rd_done   = 1'b1;
        rd_result = CORE_DS_RD_OK;
      end
      tick();
    end
    chk("t1_resp_done", 128'(cli_done), 128'(4'b0001));
    chk("t1_resp_result", 128'(cli_result), 128'(3'd0));
    chk("t1_resp_rd_valid", 128'(rd_valid), 128'(1'b0));
    chk("t1_resp_rd_param", 128'(rd_param), 128'(0));
    rd_done   = 1'b0;
    cli_valid = 4'b0000;
    tick();
    chk("t1_idle_done", 128'(cli_done), 128'(4'b0000));

    // Done outside BUSY is ignored.
    rd_done = 1'b1;
    tick();
    rd_done = 1'b0;
    tick();
    chk("idle_done_ign_cli_done", 128'(cli_done), 128'(4'b0000));
    chk("idle_done_ign_rd_valid", 128'(rd_valid), 128'(1'b0));

    // Reset during BUSY (client 1 granted), valid drops asynchronously.
    cli_valid = 4'b0010;
    tick();
    chk("rb_rd_valid_busy", 128'(rd_valid), 128'(1'b1));
    chk("rb_rd_param_busy", 128'(rd_param), 128'(exp_rd(1)));
    #2 reset_n = 1'b0;
    #1;
    chk("rb_rd_valid_async", 128'(rd_valid), 128'(1'b0));
    chk("rb_rd_param_async", 128'(rd_param), 128'(0));
    chk("rb_cli_done_async", 128'(cli_done), 128'(4'b0000));
    @(negedge clk);
    tick();
    chk("rb_cli_done_held", 128'(cli_done), 128'(4'b0000));

    // All four request; round robin from client 0, clients 1 and 3 write.
    cli_valid = 4'b1111;
    cli_write = 4'b1010;
    reset_n   = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tick();
      w = (j == 1 || j == 3);
      chk($sformatf("rr%0d_rd_valid", j), 128'(rd_valid), 128'(!w));
      chk($sformatf("rr%0d_wr_valid", j), 128'(wr_valid), 128'(w));
      if (w) begin
        chk($sformatf("rr%0d_wr_param", j), 128'(wr_param), 128'(exp_wr(j)));
        chk($sformatf("rr%0d_rd_param0", j), 128'(rd_param), 128'(0));
        wr_done   = 1'b1;
        wr_result = core_dataslot_write_result_e'(2'(j));
      end else begin
        chk($sformatf("rr%0d_rd_param", j), 128'(rd_param), 128'(exp_rd(j)));
        chk($sformatf("rr%0d_wr_param0", j), 128'(wr_param), 128'(0));
        rd_done   = 1'b1;
        rd_result = core_dataslot_read_result_e'(2'(j));
      end
      tick();
      chk($sformatf("rr%0d_cli_done", j), 128'(cli_done), 128'(4'b0001 << j));
      chk($sformatf("rr%0d_cli_result", j), 128'(cli_result), 128'(3'(j)));
      rd_done = 1'b0;
      wr_done = 1'b0;
      tick();
      chk($sformatf("rr%0d_idle_done", j), 128'(cli_done), 128'(4'b0000));
      chk($sformatf("rr%0d_idle_valid", j), 128'({rd_valid, wr_valid}), 128'(2'b00));
    end
    cli_valid = 4'b0000;
    cli_write = 4'b0000;
    tick();

    // Param change mid-BUSY, wrong-op done, and valid dropped while granted.
    cli_valid = 4'b0001;
    tick();
    chk("pc_rd_param_first", 128'(rd_param), 128'(exp_rd(0)));
    cli_param[0] = mk_param(7);
    cli_valid    = 4'b0000;
    tick();
    chk("pc_rd_param_held", 128'(rd_param), 128'(exp_rd(0)));
    wr_done   = 1'b1;
    wr_result = CORE_DS_WR_ERR_BRIDGE;
    tick();
    wr_done = 1'b0;
    chk("wd_ign_rd_valid", 128'(rd_valid), 128'(1'b1));
    chk("wd_ign_cli_done", 128'(cli_done), 128'(4'b0000));
    chk("wd_ign_rd_param", 128'(rd_param), 128'(exp_rd(0)));
    rd_done   = 1'b1;
    rd_result = CORE_DS_RD_ERR_RANGE;
    tick();
    rd_done = 1'b0;
    chk("pc_cli_done", 128'(cli_done), 128'(4'b0001));
    chk("pc_cli_result", 128'(cli_result), 128'(3'd2));
    cli_param[0] = mk_param(0);
    tick();

    // Write from client 1 with no done.
    cli_valid = 4'b0010;
    cli_write = 4'b0010;
    tick();
    cli_valid = 4'b0000;
    n = 0;
    while (wr_valid && n < 40) begin
      n++;
      tick();
    end
`ifdef DATASLOT_ARB_TIMEOUT_EN
    chk("to_busy_cycles", 128'(n), 128'(16));
    chk("to_cli_done", 128'(cli_done), 128'(4'b0010));
    chk("to_cli_result", 128'(cli_result), 128'(3'd4));
    tick();
`else
    chk("noto_busy_cycles", 128'(n), 128'(40));
    chk("noto_wr_valid", 128'(wr_valid), 128'(1'b1));
    wr_done   = 1'b1;
    wr_result = CORE_DS_WR_ERR_SLOT;
    tick();
    wr_done = 1'b0;
    chk("noto_cli_done", 128'(cli_done), 128'(4'b0010));
    chk("noto_cli_result", 128'(cli_result), 128'(3'd1));
    tick();
`endif
    chk("end_cli_done", 128'(cli_done), 128'(4'b0000));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
